// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60 sync generator.
// Default timing values and the totals and sync windows derived from them.
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    // Sum of the four segments of one timing axis
    function automatic int unsigned timing_total(input int unsigned disp, input int unsigned front,
                                                 input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL = timing_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF,
                                                   H_BACK_DEF);
    localparam int unsigned V_TOTAL = timing_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF,
                                                   V_BACK_DEF);

    localparam int unsigned H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

endpackage

// File: rtl/pix_tick_gen.sv
// Clock-enable generator: one-cycle tick every DIV system clocks.
// Reusable by any stage that runs on a divided enable instead of a derived clock.
module pix_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          w_last;

    assign w_last = (r_div_cnt == LAST);
    assign o_tick = w_last;

    // Free-running divider, wraps to zero after DIV-1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
        end else if (w_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel-tick driven h/v counters with sync, blanking and coordinates.
// Optional VGA_SYNC_REG_EN registers all decoded outputs, adding one pixel of latency.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned DIV       = 4,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(timing_total(H_DISPLAY, H_FRONT, H_SYNC,
                                                                  H_BACK) - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(timing_total(V_DISPLAY, V_FRONT, V_SYNC,
                                                                  V_BACK) - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic               w_tick;
    logic [COORD_W-1:0] r_h_count;
    logic [COORD_W-1:0] r_v_count;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_hsync;
    logic               w_vsync;
    logic               w_video;

    pix_tick_gen #(
        .DIV (DIV)
    ) u_pix_tick_gen (
        .i_clk  (clk),
        .i_rst  (reset),
        .o_tick (w_tick)
    );

    assign p_tick   = w_tick;
    assign w_h_last = (r_h_count == H_LAST);
    assign w_v_last = (r_v_count == V_LAST);

    // Horizontal/vertical counters; vertical steps on the horizontal wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h_count <= '0;
                r_v_count <= w_v_last ? '0 : r_v_count + 1'b1;
            end else begin
                r_h_count <= r_h_count + 1'b1;
            end
        end
    end

    // Sync windows and visible-area decode from the current counts
    always_comb begin
        w_hsync = ~SYNC_POL;
        w_vsync = ~SYNC_POL;
        w_video = 1'b0;
        if (r_h_count >= HS_BEG && r_h_count <= HS_END) w_hsync = SYNC_POL;
        if (r_v_count >= VS_BEG && r_v_count <= VS_END) w_vsync = SYNC_POL;
        if (r_h_count < H_VIS && r_v_count < V_VIS)     w_video = 1'b1;
    end

`ifdef VGA_SYNC_REG_EN
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_frame_pend;

    // Output stage loads the decode on each tick; the pending flag delays the
    // frame pulse so it fires with the tick that loads pixel (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_video      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_pend <= 1'b0;
        end else if (w_tick) begin
            r_hsync      <= w_hsync;
            r_vsync      <= w_vsync;
            r_video      <= w_video;
            r_x          <= r_h_count;
            r_y          <= r_v_count;
            r_frame_pend <= w_h_last & w_v_last;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = w_tick & r_frame_pend;
`else
    assign hsync       = w_hsync;
    assign vsync       = w_vsync;
    assign video_on    = w_video;
    assign x           = r_h_count;
    assign y           = r_v_count;
    assign frame_start = w_tick & w_h_last & w_v_last;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance A and a shrunken active-high
// DIV=2 instance B, both checked cycle by cycle against an arithmetic model.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic       pt_a, hs_a, vs_a, von_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       pt_b, hs_b, vs_b, von_b, fs_b;
    logic [9:0] x_b, y_b;

    int unsigned k_a = 0;
    int unsigned k_b = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .p_tick      (pt_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (von_a),
        .x           (x_a),
        .y           (y_a),
        .frame_start (fs_a)
    );

    vga_sync_gen #(
        .DIV       (2),
        .H_DISPLAY (10),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (4),
        .V_DISPLAY (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3),
        .SYNC_POL  (1'b1)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .p_tick      (pt_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .video_on    (von_b),
        .x           (x_b),
        .y           (y_b),
        .frame_start (fs_b)
    );

    wire [24:0] act_a = {pt_a, hs_a, vs_a, von_a, x_a, y_a, fs_a};
    wire [24:0] act_b = {pt_b, hs_b, vs_b, von_b, x_b, y_b, fs_b};

    // Clock edges seen since the last reset release
    always @(posedge clk or posedge rst_a) if (rst_a) k_a <= 0; else k_a <= k_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) k_b <= 0; else k_b <= k_b + 1;

    // Reference: after k edges, floor(k/div) pixels have elapsed since (0,0)
    function automatic logic [24:0] model(input int unsigned k, input int unsigned div,
                                          input int unsigned hd, input int unsigned hf,
                                          input int unsigned hs, input int unsigned hb,
                                          input int unsigned vd, input int unsigned vf,
                                          input int unsigned vs, input int unsigned vb,
                                          input logic pol);
        int unsigned ht, vt, tot, p, q, h, v;
        logic pt, fs, hsy, vsy, von;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        tot = ht * vt;
        p   = k / div;
        pt  = ((k % div) == div - 1);
`ifdef VGA_SYNC_REG_EN
        if (p == 0) return {pt, ~pol, ~pol, 1'b0, 10'd0, 10'd0, 1'b0};
        q  = (p - 1) % tot;
        fs = pt && ((p % tot) == 0);
`else
        q  = p % tot;
        fs = pt && (q == tot - 1);
`endif
        h   = q % ht;
        v   = q / ht;
        hsy = (h >= hd + hf && h < hd + hf + hs) ? pol : ~pol;
        vsy = (v >= vd + vf && v < vd + vf + vs) ? pol : ~pol;
        von = (h < hd) && (v < vd);
        return {pt, hsy, vsy, von, h[9:0], v[9:0], fs};
    endfunction

    function automatic logic [24:0] exp_a(input int unsigned k);
        return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction

    function automatic logic [24:0] exp_b(input int unsigned k);
        return model(k, 2, 10, 2, 3, 4, 6, 2, 2, 3, 1'b1);
    endfunction

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (act_a !== exp_a(0)) begin
                n_err++;
                $display("FAIL reset_a: got %h expected %h", act_a, exp_a(0));
            end
            n_vec++;
            if (act_b !== exp_b(0)) begin
                n_err++;
                $display("FAIL reset_b: got %h expected %h", act_b, exp_b(0));
            end
            n_vec++;
            if ({hs_a, vs_a, pt_a, fs_a} !== 4'b1100) begin
                n_err++;
                $display("FAIL reset_sync_idle: got %b expected 1100", {hs_a, vs_a, pt_a, fs_a});
            end
        end
    endtask

    task automatic test_tick_cadence();
        int last;
        last = -1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            n_vec++;
            if (act_a !== exp_a(k_a)) begin
                n_err++;
                $display("FAIL tick_a: got %h expected %h at k=%0d", act_a, exp_a(k_a), k_a);
            end
            if (pt_a) begin
                if (last >= 0) begin
                    n_vec++;
                    if (int'(k_a) - last != 4) begin
                        n_err++;
                        $display("FAIL tick_spacing: got %0d expected 4", int'(k_a) - last);
                    end
                end
                last = int'(k_a);
            end
        end
    endtask

    task automatic test_line();
        int hs_ticks, blank_ticks, first5, second5;
        hs_ticks = 0; blank_ticks = 0; first5 = -1; second5 = -1;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3 * 3200 + 16) begin
            @(negedge clk);
            n_vec++;
            if (act_a !== exp_a(k_a)) begin
                n_err++;
                $display("FAIL line_a: got %h expected %h at k=%0d", act_a, exp_a(k_a), k_a);
            end
            if (pt_a && y_a == 10'd1) begin
                if (!hs_a) hs_ticks++;
                if (!von_a) blank_ticks++;
            end
            if (pt_a && x_a == 10'd5) begin
                if (first5 < 0) first5 = int'(k_a);
                else if (second5 < 0) second5 = int'(k_a);
            end
        end
        n_vec++;
        if (hs_ticks != 96) begin
            n_err++;
            $display("FAIL hsync_width: got %0d expected 96", hs_ticks);
        end
        n_vec++;
        if (blank_ticks != 160) begin
            n_err++;
            $display("FAIL hblank_width: got %0d expected 160", blank_ticks);
        end
        n_vec++;
        if (second5 - first5 != 3200) begin
            n_err++;
            $display("FAIL line_period: got %0d expected 3200", second5 - first5);
        end
    endtask

    task automatic test_frame();
        int fs_cnt, vs_ticks;
        fs_cnt = 0; vs_ticks = 0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (3 * 494 + 4) begin
            @(negedge clk);
            n_vec++;
            if (act_b !== exp_b(k_b)) begin
                n_err++;
                $display("FAIL frame_b: got %h expected %h at k=%0d", act_b, exp_b(k_b), k_b);
            end
            if (fs_b) fs_cnt++;
            if (pt_b && vs_b && k_b < 494) vs_ticks++;
        end
        n_vec++;
        if (fs_cnt != 3) begin
            n_err++;
            $display("FAIL frame_pulses: got %0d expected 3", fs_cnt);
        end
        n_vec++;
        if (vs_ticks != 2 * 19) begin
            n_err++;
            $display("FAIL vsync_width: got %0d expected 38", vs_ticks);
        end
    endtask

    task automatic test_async_reset();
        int unsigned run;
        run = $urandom_range(1300, 1150);
        repeat (run) begin
            @(negedge clk);
            n_vec++;
            if (act_a !== exp_a(k_a)) begin
                n_err++;
                $display("FAIL pre_reset_a: got %h expected %h at k=%0d", act_a, exp_a(k_a), k_a);
            end
        end
        #1 rst_a = 1'b1;
        #1;
        n_vec++;
        if (act_a !== exp_a(0)) begin
            n_err++;
            $display("FAIL async_clear_a: got %h expected %h", act_a, exp_a(0));
        end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (act_a !== exp_a(0)) begin
                n_err++;
                $display("FAIL reset_hold_a: got %h expected %h", act_a, exp_a(0));
            end
        end
        rst_a = 1'b0;
        repeat (200) begin
            @(negedge clk);
            n_vec++;
            if (act_a !== exp_a(k_a)) begin
                n_err++;
                $display("FAIL restart_a: got %h expected %h at k=%0d", act_a, exp_a(k_a), k_a);
            end
        end
    endtask

    task automatic test_random_resets();
        int unsigned run, hold;
        for (int r = 0; r < 6; r++) begin
            run  = $urandom_range(700, 20);
            hold = $urandom_range(4, 1);
            repeat (run) begin
                @(negedge clk);
                n_vec++;
                if (act_b !== exp_b(k_b)) begin
                    n_err++;
                    $display("FAIL rand_run_b: got %h expected %h at k=%0d", act_b, exp_b(k_b),
                             k_b);
                end
            end
            #($urandom_range(4, 1)) rst_b = 1'b1;
            #1;
            n_vec++;
            if (act_b !== exp_b(0)) begin
                n_err++;
                $display("FAIL rand_async_b: got %h expected %h", act_b, exp_b(0));
            end
            repeat (hold) @(negedge clk);
            rst_b = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_tick_cadence();
        test_line();
        test_frame();
        test_async_reset();
        test_random_resets();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
